// File: rtl/fighter_pkg.sv
// Shared definitions for the fighter renderer: jump state encodings,
// palette entries and default geometry.
package fighter_pkg;

  typedef enum logic [1:0] {
    JS_GROUND = 2'b00,
    JS_RISE   = 2'b01,
    JS_FALL   = 2'b10,
    JS_BAD    = 2'b11
  } jump_state_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  localparam rgb_t COL_BLACK   = '{r: 3'd0, g: 3'd0, b: 2'd0};
  localparam rgb_t COL_SKY     = '{r: 3'd0, g: 3'd3, b: 2'd3};
  localparam rgb_t COL_GROUND  = '{r: 3'd0, g: 3'd5, b: 2'd0};
  localparam rgb_t COL_SPRITE  = '{r: 3'd7, g: 3'd0, b: 2'd0};
  localparam rgb_t COL_OUTLINE = '{r: 3'd7, g: 3'd7, b: 2'd3};

  localparam int DEF_SPRITE_W    = 32;
  localparam int DEF_SPRITE_H    = 64;
  localparam int DEF_GROUND_Y    = 400;
  localparam int DEF_X_INIT      = 100;
  localparam int DEF_X_MIN       = 0;
  localparam int DEF_X_MAX       = 640;
  localparam int DEF_MOVE_STEP   = 2;
  localparam int DEF_JUMP_STEP   = 4;
  localparam int DEF_JUMP_HEIGHT = 96;
  localparam int DEF_FRAME_LINE  = 480;

endpackage

// File: rtl/fighter_motion.sv
// Per-frame sprite motion: frame tick detection, jump request capture,
// horizontal move with saturation and the jump state machine.
//
//   state     | meaning
//   JS_GROUND | standing on the ground, waiting for a jump request
//   JS_RISE   | climbing JUMP_STEP per frame until JUMP_HEIGHT
//   JS_FALL   | descending JUMP_STEP per frame until back on ground
//   JS_BAD    | unreachable; recovers to JS_GROUND with jump_h cleared
import fighter_pkg::*;

module fighter_motion #(
  parameter int SPRITE_W    = DEF_SPRITE_W,
  parameter int X_INIT      = DEF_X_INIT,
  parameter int X_MIN       = DEF_X_MIN,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int MOVE_STEP   = DEF_MOVE_STEP,
  parameter int JUMP_STEP   = DEF_JUMP_STEP,
  parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
  parameter int FRAME_LINE  = DEF_FRAME_LINE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  CounterY,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [9:0]  sprite_x,
  output logic [9:0]  jump_h,
  output jump_state_t jump_state
);

  localparam logic [10:0] X_LO   = 11'(X_MIN);
  localparam logic [10:0] X_HI   = 11'(X_MAX - SPRITE_W);
  localparam logic [10:0] STEP_X = 11'(MOVE_STEP);
  localparam logic [9:0]  STEP_J = 10'(JUMP_STEP);
  localparam logic [9:0]  APEX   = 10'(JUMP_HEIGHT);

  logic        y_match, y_match_q, frame_tick;
  logic        btn_jump_q, jump_rise, jump_req;
  logic [10:0] x_ext, x_next;
  jump_state_t state_next;
  logic [9:0]  jump_h_next;

  assign y_match    = (CounterY == 9'(FRAME_LINE));
  assign frame_tick = y_match & ~y_match_q;
  assign jump_rise  = btn_jump & ~btn_jump_q;

  // Previous-cycle copies for the frame-line and jump-button edge detectors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_match_q  <= 1'b0;
      btn_jump_q <= 1'b0;
    end else begin
      y_match_q  <= y_match;
      btn_jump_q <= btn_jump;
    end
  end

  // Latch a jump press while grounded; drop it once the FSM takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jump_req <= 1'b0;
    end else if (frame_tick && jump_state == JS_GROUND && jump_req) begin
      jump_req <= 1'b0;
    end else if (jump_rise && jump_state == JS_GROUND) begin
      jump_req <= 1'b1;
    end
  end

  // Next horizontal position, saturating at both limits in 11 bits.
  always_comb begin
    x_ext  = {1'b0, sprite_x};
    x_next = x_ext;
    if (btn_left && !btn_right) begin
      x_next = (x_ext < X_LO + STEP_X) ? X_LO : x_ext - STEP_X;
    end else if (btn_right && !btn_left) begin
      x_next = (x_ext + STEP_X > X_HI) ? X_HI : x_ext + STEP_X;
    end
  end

  // Horizontal position register, updated once per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sprite_x <= 10'(X_INIT);
    end else if (frame_tick) begin
      sprite_x <= x_next[9:0];
    end
  end

  // Jump FSM next state and height.
  always_comb begin
    state_next  = jump_state;
    jump_h_next = jump_h;
    case (jump_state)
      JS_GROUND: begin
        if (jump_req) state_next = JS_RISE;
      end
      JS_RISE: begin
        jump_h_next = jump_h + STEP_J;
        if (jump_h_next == APEX) state_next = JS_FALL;
      end
      JS_FALL: begin
        jump_h_next = jump_h - STEP_J;
        if (jump_h_next == 10'd0) state_next = JS_GROUND;
      end
      default: begin
        state_next  = JS_GROUND;
        jump_h_next = 10'd0;
      end
    endcase
  end

  // Jump FSM state register, advanced once per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jump_state <= JS_GROUND;
      jump_h     <= 10'd0;
    end else if (frame_tick) begin
      jump_state <= state_next;
      jump_h     <= jump_h_next;
    end
  end

endmodule

// File: rtl/fighter_pixel_renderer.sv
// Renders one fighter sprite over ground and sky from the scan position.
// Colour and syncs share a 2-clock pipeline so they stay aligned.
// Optional macro HITBOX_OUTLINE_EN draws a white 1-pixel sprite border.
import fighter_pkg::*;

module fighter_pixel_renderer #(
  parameter int SPRITE_W    = DEF_SPRITE_W,
  parameter int SPRITE_H    = DEF_SPRITE_H,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int X_INIT      = DEF_X_INIT,
  parameter int X_MIN       = DEF_X_MIN,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int MOVE_STEP   = DEF_MOVE_STEP,
  parameter int JUMP_STEP   = DEF_JUMP_STEP,
  parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
  parameter int FRAME_LINE  = DEF_FRAME_LINE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] CounterX,
  input  logic [8:0] CounterY,
  input  logic       inDisplayArea,
  input  logic       vga_h_sync_in,
  input  logic       vga_v_sync_in,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic [9:0] sprite_x,
  output logic [1:0] jump_state
);

  localparam logic [10:0] W11    = 11'(SPRITE_W);
  localparam logic [10:0] GY11   = 11'(GROUND_Y);
  localparam logic [10:0] BASE11 = 11'(GROUND_Y - SPRITE_H);

  logic [9:0]  jump_h;
  jump_state_t js;
  logic [10:0] cx11, cy11, sx11, top11;
  logic        hit, ground;
  logic        s1_hit, s1_ground, s1_de, s1_hs, s1_vs;
  rgb_t        pix_col, rgb_q;
`ifdef HITBOX_OUTLINE_EN
  logic        border, s1_border;
`endif

  fighter_motion #(
    .SPRITE_W   (SPRITE_W),
    .X_INIT     (X_INIT),
    .X_MIN      (X_MIN),
    .X_MAX      (X_MAX),
    .MOVE_STEP  (MOVE_STEP),
    .JUMP_STEP  (JUMP_STEP),
    .JUMP_HEIGHT(JUMP_HEIGHT),
    .FRAME_LINE (FRAME_LINE)
  ) u_motion (
    .clk       (clk),
    .reset     (reset),
    .CounterY  (CounterY),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump),
    .sprite_x  (sprite_x),
    .jump_h    (jump_h),
    .jump_state(js)
  );

  assign jump_state = js;

  assign cx11   = {1'b0, CounterX};
  assign cy11   = {2'b00, CounterY};
  assign sx11   = {1'b0, sprite_x};
  assign top11  = BASE11 - {1'b0, jump_h};
  assign hit    = (cx11 >= sx11) && (cx11 < sx11 + W11) &&
                  (cy11 >= top11) && (cy11 < GY11);
  assign ground = (cy11 >= GY11);
`ifdef HITBOX_OUTLINE_EN
  assign border = hit && ((cx11 == sx11) || (cx11 == sx11 + W11 - 11'd1) ||
                          (cy11 == top11) || (cy11 == GY11 - 11'd1));
`endif

  // Stage 1: register pixel classification and syncs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_hit    <= 1'b0;
      s1_ground <= 1'b0;
      s1_de     <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
`ifdef HITBOX_OUTLINE_EN
      s1_border <= 1'b0;
`endif
    end else begin
      s1_hit    <= hit;
      s1_ground <= ground;
      s1_de     <= inDisplayArea;
      s1_hs     <= vga_h_sync_in;
      s1_vs     <= vga_v_sync_in;
`ifdef HITBOX_OUTLINE_EN
      s1_border <= border;
`endif
    end
  end

  // Colour priority: blanking, outline (optional), sprite, ground, sky.
  always_comb begin
    pix_col = COL_SKY;
    if (!s1_de) begin
      pix_col = COL_BLACK;
`ifdef HITBOX_OUTLINE_EN
    end else if (s1_border) begin
      pix_col = COL_OUTLINE;
`endif
    end else if (s1_hit) begin
      pix_col = COL_SPRITE;
    end else if (s1_ground) begin
      pix_col = COL_GROUND;
    end
  end

  // Stage 2: register final colour and syncs for the VGA pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q      <= COL_BLACK;
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
    end else begin
      rgb_q      <= pix_col;
      vga_h_sync <= s1_hs;
      vga_v_sync <= s1_vs;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_fighter_pixel_renderer.sv
// Scoreboard bench for fighter_pixel_renderer with a behavioural model of
// sprite motion and pixel colour.
module tb_fighter_pixel_renderer;

  logic       clk_tb = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] counter_x = '0;
  logic [8:0] counter_y = '0;
  logic       in_display = 1'b0;
  logic       hs_in = 1'b1, vs_in = 1'b1;
  logic       btn_l = 1'b0, btn_r = 1'b0, btn_j = 1'b0;
  logic [2:0] vga_r, vga_g;
  logic [1:0] vga_b;
  logic       vga_h_sync, vga_v_sync;
  logic [9:0] sprite_x;
  logic [1:0] jump_state;

  always #5 clk_tb = ~clk_tb;

  fighter_pixel_renderer dut (
    .clk          (clk_tb),
    .reset        (rst_n),
    .CounterX     (counter_x),
    .CounterY     (counter_y),
    .inDisplayArea(in_display),
    .vga_h_sync_in(hs_in),
    .vga_v_sync_in(vs_in),
    .btn_left     (btn_l),
    .btn_right    (btn_r),
    .btn_jump     (btn_j),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_h_sync   (vga_h_sync),
    .vga_v_sync   (vga_v_sync),
    .sprite_x     (sprite_x),
    .jump_state   (jump_state)
  );

  typedef struct {
    int rgb;
    bit hs;
    bit vs;
    int sx;
    int st;
  } exp_t;

  exp_t sb[$];
  bit   sb_en = 0;
  bit   release_pending = 0;
  int   total = 0, bad = 0;

  // reference model: position, jump height, phase (0 ground,1 rise,2 fall)
  int m_sx, m_jh, m_st;
  bit m_req, m_prev_j, m_prev_match;
  bit cur_l = 0, cur_r = 0, cur_j = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_sx = 100; m_jh = 0; m_st = 0;
    m_req = 0; m_prev_j = 0; m_prev_match = 0;
  endtask

  function automatic int pack_rgb(int r, int g, int b);
    return (r << 5) | (g << 2) | b;
  endfunction

  function automatic int ref_colour(int cx, int cy, bit de, int sx, int jh);
    int top;
    bit in_spr, edge_px;
    top = 400 - 64 - jh;
    in_spr = (cx >= sx) && (cx < sx + 32) && (cy >= top) && (cy < 400);
    edge_px = in_spr && (cx == sx || cx == sx + 31 || cy == top || cy == 399);
    if (!de) return 0;
`ifdef HITBOX_OUTLINE_EN
    if (edge_px) return pack_rgb(7, 7, 3);
`else
    if (edge_px && !in_spr) return 0;
`endif
    if (in_spr) return pack_rgb(7, 0, 0);
    if (cy >= 400) return pack_rgb(0, 5, 0);
    return pack_rgb(0, 3, 3);
  endfunction

  // One clock of game logic as seen from the buttons and scan line.
  task automatic model_step(input int cy, input bit l, input bit r, input bit j);
    bit match, tick, rise, consumed;
    int st0;
    match = (cy == 480);
    tick = match && !m_prev_match;
    rise = j && !m_prev_j;
    st0 = m_st;
    consumed = 0;
    if (tick) begin
      if (l && !r) m_sx = (m_sx - 2 < 0) ? 0 : m_sx - 2;
      else if (r && !l) m_sx = (m_sx + 2 > 608) ? 608 : m_sx + 2;
      if (st0 == 0 && m_req) begin
        m_st = 1; m_req = 0; consumed = 1;
      end else if (st0 == 1) begin
        m_jh += 4;
        if (m_jh == 96) m_st = 2;
      end else if (st0 == 2) begin
        m_jh -= 4;
        if (m_jh == 0) m_st = 0;
      end
    end
    if (rise && st0 == 0 && !consumed) m_req = 1;
    m_prev_match = match;
    m_prev_j = j;
  endtask

  task automatic drive(input int cx, input int cy, input bit de, input bit hs, input bit vs);
    exp_t e;
    @(negedge clk_tb);
    if (release_pending) begin
      sb.delete();
      model_reset();
      rst_n = 1'b1;
      sb_en = 1;
      release_pending = 0;
    end
    counter_x = cx[9:0];
    counter_y = cy[8:0];
    in_display = de;
    hs_in = hs;
    vs_in = vs;
    btn_l = cur_l;
    btn_r = cur_r;
    btn_j = cur_j;
    if (sb_en) begin
      e.rgb = ref_colour(cx, cy, de, m_sx, m_jh);
      e.hs = hs;
      e.vs = vs;
      model_step(cy, cur_l, cur_r, cur_j);
      e.sx = m_sx;
      e.st = m_st;
      sb.push_back(e);
    end
  endtask

  task automatic rand_pix();
    int cx, cy;
    if ($urandom_range(0, 1) == 1) begin
      cx = m_sx + $urandom_range(0, 40) - 4;
      if (cx < 0) cx = 0;
      if (cx > 1023) cx = 1023;
    end else begin
      cx = $urandom_range(0, 1023);
    end
    if ($urandom_range(0, 1) == 1) cy = $urandom_range(200, 420);
    else cy = $urandom_range(0, 511);
    if (cy == 480) cy = 479;
    drive(cx, cy, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  // One short frame: a few random pixels, then the frame line held 3 clocks.
  task automatic frame(input bit pulse);
    int hold_x;
    for (int i = 0; i < 5; i++) begin
      if (pulse) cur_j = (i == 1 || i == 2);
      rand_pix();
    end
    cur_j = 0;
    hold_x = $urandom_range(0, 799);
    repeat (3) drive(hold_x, 480, 1'b0, 1'b1, $urandom_range(0, 1));
    rand_pix();
  endtask

  task automatic chk_state(input string name, input int sx, input int st);
    @(posedge clk_tb);
    #1;
    check({name, "_x"}, sprite_x, sx);
    check({name, "_state"}, jump_state, st);
  endtask

  task automatic do_reset();
    @(negedge clk_tb);
    sb_en = 0;
    rst_n = 1'b0;
    counter_y = 9'd200;
    #1;
    check("rst_async_state", jump_state, 0);
    repeat (3) @(posedge clk_tb);
    #1;
    check("rst_x", sprite_x, 100);
    check("rst_state", jump_state, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_hs", vga_h_sync, 1);
    check("rst_vs", vga_v_sync, 1);
    release_pending = 1;
  endtask

  // Scoreboard monitor: colour/syncs lag stimulus by two clocks.
  initial begin
    exp_t e, lat;
    forever begin
      @(posedge clk_tb);
      #1;
      if (sb_en && sb.size() >= 2) begin
        lat = sb[$];
        e = sb.pop_front();
        check("rgb", {vga_r, vga_g, vga_b}, e.rgb);
        check("hsync", vga_h_sync, e.hs);
        check("vsync", vga_v_sync, e.vs);
        check("sprite_x", sprite_x, lat.sx);
        check("jump_state", jump_state, lat.st);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();
    frame(0);
    chk_state("first_tick", 100, 0);

    // directed pixel latency and colour checks with sprite at x=100 on ground
    drive(110, 350, 1, 1, 1);
    drive(110, 450, 1, 0, 1);
    drive(110, 350, 0, 1, 0);
    drive(100, 336, 1, 1, 1);
    drive(101, 337, 1, 1, 1);
    drive(131, 399, 1, 0, 0);
    drive(132, 399, 1, 1, 1);
    drive(99, 350, 1, 1, 1);
    drive(110, 335, 1, 1, 1);

    cur_r = 1;
    repeat (5) frame(0);
    chk_state("right5", 110, 0);
    cur_l = 1;
    repeat (3) frame(0);
    chk_state("both3", 110, 0);
    cur_r = 0;
    repeat (55) frame(0);
    chk_state("left_zero", 0, 0);
    repeat (3) frame(0);
    chk_state("left_hold", 0, 0);
    cur_l = 0;
    cur_r = 1;
    repeat (310) frame(0);
    chk_state("right_sat", 608, 0);
    cur_r = 0;

    // jump sequence from a fresh start
    do_reset();
    frame(1);
    chk_state("jump_start", 100, 1);
    repeat (23) frame(0);
    chk_state("rise_23", 100, 1);
    frame(0);
    chk_state("apex", 100, 2);
    for (int i = 0; i < 23; i++) frame(i == 3);
    chk_state("fall_23", 100, 2);
    frame(0);
    chk_state("landed", 100, 0);
    repeat (2) frame(0);
    chk_state("no_rejump", 100, 0);

    // second pulse during rise must not queue another jump
    frame(1);
    frame(1);
    repeat (47) frame(0);
    chk_state("rise_pulse_ignored", 100, 0);

    // reset mid-jump
    frame(1);
    repeat (10) frame(0);
    do_reset();
    frame(0);
    chk_state("post_reset", 100, 0);

    // randomized play
    for (int f = 0; f < 200; f++) begin
      cur_l = ($urandom_range(0, 2) == 0);
      cur_r = ($urandom_range(0, 2) == 0);
      frame($urandom_range(0, 7) == 0);
    end
    cur_l = 0;
    cur_r = 0;
    repeat (3) rand_pix();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
